// File: rtl/imem_stream_loader.sv
// Purpose: instruction memory loaded by a valid/ready word stream, then fetched by the core.
// Latency: one accept per cycle on load; fetch data, valid and fault registered one cycle after the request.
// Backpressure: ld_ready is high only in LOAD; fetch requests in LOAD or in a reload cycle are dropped.
module imem_stream_loader #(
    parameter int             IW    = 32,
    parameter int             DEPTH = 256,
    parameter int             PCW   = 64,
    parameter logic [IW-1:0]  NOP   = 32'h00000013
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ld_valid,
    output logic                         ld_ready,
    input  logic [IW-1:0]                ld_data,
    input  logic                         ld_last,
    input  logic                         reload,
    output logic [$clog2(DEPTH+1)-1:0]   ld_count,
    output logic                         ld_overflow,
    output logic                         core_run,
    input  logic                         fetch_en,
    input  logic [PCW-1:0]               fetch_pc,
    output logic [IW-1:0]                fetch_instr,
    output logic                         fetch_vld,
    output logic                         fetch_fault
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    typedef enum logic {LOAD, RUN} state_t;

    state_t          state, state_nxt;
    logic            accept;
    logic            ovf_set;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   idx;
    logic            misalign;
    logic            upper_set;
    logic            beyond;
    logic            fault;
    logic            do_fetch;
    logic [IW-1:0]   mem [DEPTH];

    // State register; reset always lands in LOAD.
    always_ff @(posedge clk) begin
        if (rst) state <= LOAD;
        else     state <= state_nxt;
    end

    // Next state, load handshake and core release.
    always_comb begin
        state_nxt = state;
        ld_ready  = 1'b0;
        core_run  = 1'b0;
        accept    = 1'b0;
        ovf_set   = 1'b0;
        case (state)
            LOAD: begin
                ld_ready = 1'b1;
                accept   = ld_valid;
                if (ld_valid) begin
                    if (ld_last) begin
                        state_nxt = RUN;
                    end else if (wr_ptr == AW'(DEPTH-1)) begin
                        // Memory is full without an end marker: store the word and run anyway.
                        ovf_set   = 1'b1;
                        state_nxt = RUN;
                    end
                end
            end
            RUN: begin
                core_run = 1'b1;
                if (reload) state_nxt = LOAD;
            end
            default: state_nxt = LOAD;
        endcase
    end

    // Write pointer, loaded-word count and sticky overflow; reload restarts them but keeps memory.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            ld_count    <= '0;
            ld_overflow <= 1'b0;
        end else if (core_run && reload) begin
            wr_ptr      <= '0;
            ld_count    <= '0;
            ld_overflow <= 1'b0;
        end else if (accept) begin
            wr_ptr   <= wr_ptr + AW'(1);
            ld_count <= ld_count + CW'(1);
            if (ovf_set) ld_overflow <= 1'b1;
        end
    end

    // Memory write port; the array is deliberately not reset.
    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr] <= ld_data;
    end

    // Fetch address decode: misaligned, beyond the loaded program, or above the array span all fault.
    assign idx      = fetch_pc[AW+1:2];
    assign misalign = |fetch_pc[1:0];
    assign beyond   = ({1'b0, idx} >= ld_count);
    generate
        if (PCW > AW + 2) begin : g_upper
            assign upper_set = |fetch_pc[PCW-1:AW+2];
        end else begin : g_no_upper
            assign upper_set = 1'b0;
        end
    endgenerate
    assign fault    = misalign | upper_set | beyond;
    // A fetch issued together with reload is dropped since the program is about to change.
    assign do_fetch = core_run & fetch_en & ~reload;

    // Registered fetch port; instruction holds when no fetch is performed.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_vld   <= 1'b0;
            fetch_fault <= 1'b0;
            fetch_instr <= NOP;
        end else begin
            fetch_vld   <= do_fetch;
            fetch_fault <= do_fetch & fault;
            if (do_fetch) fetch_instr <= fault ? NOP : mem[idx];
        end
    end

endmodule
